// File: rtl/stage0_pkg.sv
// Shared constants, FSM state type and beat-total helper for the stage-0 config loader.
package stage0_pkg;

  localparam int DEF_INT_BITS = 13;
  localparam int DEF_LANES    = 9;
  localparam int DEF_W_BEATS  = 5;
  localparam int DEF_B_BEATS  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Total beats for one load: kernel weights (mode 0) or BN parameters (mode 1).
  function automatic int beatTotal(input logic mode, input int lanes,
                                   input int wBeats, input int bBeats);
    return lanes * (mode ? bBeats : wBeats);
  endfunction

endpackage

// File: rtl/stage0_cfg_loader_if.sv
// Host-side request/beat bus and chain-side outputs of the stage-0 config loader.
interface stage0_cfg_loader_if
  import stage0_pkg::*;
#(
  parameter int INT_BITS = DEF_INT_BITS
) ();

  logic                start;
  logic                mode_in;
  logic                relu_in;
  logic                abort;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [INT_BITS-1:0] cfg_data [1:0];
  logic                weight_en;
  logic                weight_mode;
  logic                relu_sel;
  logic [INT_BITS-1:0] BN_config_out [1:0];
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, mode_in, relu_in, abort, cfg_valid, cfg_data,
    input  cfg_ready, weight_en, weight_mode, relu_sel, BN_config_out,
           busy, done, err
  );

  modport slave (
    input  start, mode_in, relu_in, abort, cfg_valid, cfg_data,
    output cfg_ready, weight_en, weight_mode, relu_sel, BN_config_out,
           busy, done, err
  );

endinterface

// File: rtl/stage0_cfg_loader.sv
// Streams host config beats into the DW_BN_ReLU daisy chain, one shift strobe per beat,
// with a one-cycle registered latency from acceptance to the chain head.
module stage0_cfg_loader
  import stage0_pkg::*;
#(
  parameter int int_bits = DEF_INT_BITS,
  parameter int LANES    = DEF_LANES,
  parameter int W_BEATS  = DEF_W_BEATS,
  parameter int B_BEATS  = DEF_B_BEATS
) (
  input  logic               clk,
  input  logic               reset,
  stage0_cfg_loader_if.slave bus
);

  localparam int MAX_TOTAL = (W_BEATS > B_BEATS) ? LANES * W_BEATS : LANES * B_BEATS;
  localparam int CNT_W     = $clog2(MAX_TOTAL + 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_beatCnt;
  logic                r_weightEn;
  logic                r_weightMode;
  logic                r_reluSel;
  logic                r_done;
  logic                r_err;
  logic [int_bits-1:0] r_cfgOut [1:0];

  logic                w_cfgReady;
  logic                w_accept;
  logic [CNT_W-1:0]    w_lastBeat;

  // Abort blocks acceptance in the same cycle so the aborted beat never reaches the chain.
  assign w_cfgReady = (r_state == LOAD) && !bus.abort;
  assign w_accept   = bus.cfg_valid && w_cfgReady;
  assign w_lastBeat = CNT_W'(beatTotal(r_weightMode, LANES, W_BEATS, B_BEATS) - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_beatCnt    <= '0;
      r_weightEn   <= 1'b0;
      r_weightMode <= 1'b0;
      r_reluSel    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cfgOut[0]  <= '0;
      r_cfgOut[1]  <= '0;
    end else begin
      r_weightEn <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_weightMode <= bus.mode_in;
            r_reluSel    <= bus.relu_in;
            r_beatCnt    <= '0;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          r_err <= bus.start;
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            r_weightEn  <= 1'b1;
            r_cfgOut[0] <= bus.cfg_data[0];
            r_cfgOut[1] <= bus.cfg_data[1];
            r_beatCnt   <= r_beatCnt + CNT_W'(1);
            // The final beat's strobe and done appear together while in DONE.
            if (r_beatCnt == w_lastBeat) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_err   <= bus.start;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready        = w_cfgReady;
  assign bus.weight_en        = r_weightEn;
  assign bus.weight_mode      = r_weightMode;
  assign bus.relu_sel         = r_reluSel;
  assign bus.BN_config_out[0] = r_cfgOut[0];
  assign bus.BN_config_out[1] = r_cfgOut[1];
  assign bus.busy             = (r_state != IDLE);
  assign bus.done             = r_done;
  assign bus.err              = r_err;

endmodule

// File: tb/tb_stage0_cfg_loader.sv
// Directed scoreboard bench for stage0_cfg_loader: the driver queues expected chain beats,
// a negedge monitor pops them against weight_en/done/BN_config_out.
module tb_stage0_cfg_loader;
  import stage0_pkg::*;

  localparam int INT_BITS = DEF_INT_BITS;

  typedef struct {
    logic [INT_BITS-1:0] d0;
    logic [INT_BITS-1:0] d1;
    bit                  isLast;
    int                  due;
  } beat_t;

  logic clk;
  logic reset;
  int   cycleCount;
  bit   resetAtEdge;
  int   vectorCount;
  int   missCount;

  beat_t               expQ[$];
  logic [INT_BITS-1:0] lastData0;
  logic [INT_BITS-1:0] lastData1;

  stage0_cfg_loader_if #(.INT_BITS(INT_BITS)) bus ();

  stage0_cfg_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cycleCount  <= cycleCount + 1;
    resetAtEdge <= !reset;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, actual, expected, cycleCount);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one valid beat {k, k+100} for a cycle; its strobe is due one cycle later.
  task automatic applyStimulus(input int k, input bit isLast);
    beat_t b;
    bus.cfg_valid    = 1'b1;
    bus.cfg_data[0]  = INT_BITS'(k);
    bus.cfg_data[1]  = INT_BITS'(k + 100);
    b.d0     = INT_BITS'(k);
    b.d1     = INT_BITS'(k + 100);
    b.isLast = isLast;
    b.due    = cycleCount + 1;
    expQ.push_back(b);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic startLoad(input logic mode, input logic relu);
    bus.start   = 1'b1;
    bus.mode_in = mode;
    bus.relu_in = relu;
    tick();
    bus.start = 1'b0;
    checkOutput("busy after start", bus.busy, 1);
    checkOutput("cfg_ready in LOAD", bus.cfg_ready, 1);
    checkOutput("err after idle start", bus.err, 0);
  endtask

  task automatic drainAndCheck(input string name);
    tick();
    tick();
    tick();
    checkOutput({name, " pulses outstanding"}, expQ.size(), 0);
    checkOutput({name, " busy at end"}, bus.busy, 0);
  endtask

  task automatic checkAllZero();
    checkOutput("reset cfg_ready", bus.cfg_ready, 0);
    checkOutput("reset weight_en", bus.weight_en, 0);
    checkOutput("reset weight_mode", bus.weight_mode, 0);
    checkOutput("reset relu_sel", bus.relu_sel, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset err", bus.err, 0);
    checkOutput("reset out0", bus.BN_config_out[0], 0);
    checkOutput("reset out1", bus.BN_config_out[1], 0);
  endtask

  // Monitor: strobe timing, done alignment, beat data and hold behaviour between strobes.
  initial begin
    beat_t h;
    bit    expWe;
    bit    expDone;
    forever begin
      @(negedge clk);
      if (resetAtEdge) begin
        expQ.delete();
        lastData0 = '0;
        lastData1 = '0;
      end
      expWe   = (expQ.size() > 0) && (expQ[0].due == cycleCount);
      expDone = expWe && expQ[0].isLast;
      if (bus.weight_en || expWe)
        checkOutput("weight_en timing", bus.weight_en, expWe);
      if (bus.done || expDone)
        checkOutput("done pulse", bus.done, expDone);
      if (expWe) begin
        h = expQ.pop_front();
        if (bus.weight_en) begin
          checkOutput("beat data0", bus.BN_config_out[0], h.d0);
          checkOutput("beat data1", bus.BN_config_out[1], h.d1);
        end
        lastData0 = h.d0;
        lastData1 = h.d1;
      end else if (!bus.weight_en) begin
        checkOutput("hold data0", bus.BN_config_out[0], lastData0);
        checkOutput("hold data1", bus.BN_config_out[1], lastData1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectorCount   = 0;
    missCount     = 0;
    lastData0     = '0;
    lastData1     = '0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.mode_in   = 1'b0;
    bus.relu_in   = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data[0] = '0;
    bus.cfg_data[1] = '0;

    tick();
    tick();
    checkAllZero();
    reset = 1'b1;
    tick();

    $display("[TB] full kernel load");
    startLoad(1'b0, 1'b1);
    for (int k = 0; k < 45; k++) applyStimulus(k, k == 44);
    checkOutput("kernel relu_sel", bus.relu_sel, 1);
    checkOutput("kernel weight_mode", bus.weight_mode, 0);
    drainAndCheck("kernel");

    $display("[TB] BN load with gaps");
    startLoad(1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(200 + k, k == 8);
      if (k < 8) begin
        bus.cfg_data[0] = '1;
        bus.cfg_data[1] = '1;
        tick();
      end
    end
    checkOutput("bn weight_mode", bus.weight_mode, 1);
    drainAndCheck("bn");

    $display("[TB] rejected start");
    startLoad(1'b0, 1'b1);
    for (int k = 0; k < 45; k++) begin
      if (k == 10) begin
        bus.start   = 1'b1;
        bus.mode_in = 1'b1;
        bus.relu_in = 1'b0;
      end
      applyStimulus(k, k == 44);
      if (k == 10) begin
        bus.start = 1'b0;
        checkOutput("err on rejected start", bus.err, 1);
      end
      if (k == 11) begin
        checkOutput("err one cycle", bus.err, 0);
        checkOutput("weight_mode kept", bus.weight_mode, 0);
        checkOutput("relu_sel kept", bus.relu_sel, 1);
      end
    end
    drainAndCheck("reject");

    $display("[TB] abort mid-load");
    startLoad(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) applyStimulus(k, 1'b0);
    bus.abort       = 1'b1;
    bus.cfg_valid   = 1'b1;
    bus.cfg_data[0] = INT_BITS'(20);
    bus.cfg_data[1] = INT_BITS'(120);
    #1;
    checkOutput("cfg_ready under abort", bus.cfg_ready, 0);
    tick();
    bus.abort     = 1'b0;
    bus.cfg_valid = 1'b0;
    checkOutput("busy after abort", bus.busy, 0);
    checkOutput("weight_en after abort", bus.weight_en, 0);
    checkOutput("done after abort", bus.done, 0);
    drainAndCheck("abort");
    startLoad(1'b1, 1'b1);
    for (int k = 0; k < 9; k++) applyStimulus(300 + k, k == 8);
    checkOutput("post-abort relu_sel", bus.relu_sel, 1);
    drainAndCheck("post-abort");

    $display("[TB] reset mid-load");
    startLoad(1'b0, 1'b1);
    for (int k = 0; k < 30; k++) applyStimulus(k, 1'b0);
    reset           = 1'b0;
    bus.cfg_valid   = 1'b1;
    bus.cfg_data[0] = INT_BITS'(30);
    bus.cfg_data[1] = INT_BITS'(130);
    tick();
    reset         = 1'b1;
    bus.cfg_valid = 1'b0;
    checkAllZero();
    drainAndCheck("reset");
    startLoad(1'b1, 1'b0);
    for (int k = 0; k < 9; k++) applyStimulus(400 + k, k == 8);
    drainAndCheck("post-reset");

    $display("[TB] start and abort together in IDLE");
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    bus.mode_in = 1'b1;
    bus.relu_in = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("start wins busy", bus.busy, 1);
    checkOutput("start wins err", bus.err, 0);
    for (int k = 0; k < 9; k++) applyStimulus(500 + k, k == 8);
    drainAndCheck("start-abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
